ama_riscv_fwd_scoreboard: RTL and testbench
===========================================

// Module: ama_riscv_fwd_scoreboard
// PURPOSE
//  Parametrised operand-forwarding and hazard unit for the ID stage. Tracks in-flight
//  register writes over FWD_DEPTH pipeline stages (EX..WB) with per-entry result-latency
//  countdown. Produces a per-source forward select (youngest ready producer) and a stall
//  (load-use / multi-cycle hazard). Sits beside the ID/EX boundary; drives the operand muxes.
// PARAMETERS
//  NUM_SRC    2  number of source operands checked per instruction
//  RF_ADDR_W  5  register-file address width
//  FWD_DEPTH  3  tracked stages; stage 1=EX, 2=MEM, 3=WB; beyond that the value is in the RF
//  LAT_W      2  width of latency field/counter; must hold FWD_DEPTH-1
// PORTS
//  clk        in   1                    clock, rising edge
//  rst        in   1                    asynchronous, active-high reset
//  id_valid   in   1                    valid instruction in ID
//  rs_id      in   NUM_SRC*RF_ADDR_W    source addresses; src i at [i*RF_ADDR_W +: RF_ADDR_W]
//  rs_used    in   NUM_SRC              src i is read by the instruction
//  rd_id      in   RF_ADDR_W            destination of the ID instruction
//  reg_we_id  in   1                    ID instruction writes rd
//  lat_id     in   LAT_W                stages after EX entry until the result is forwardable
//                                       (0=ALU, 1=load)
//  flush      in   1                    kill the ID instruction (branch/jump resolved in EX)
//  fwd_sel    out  NUM_SRC*FWD_SEL_W    per src: 0=RF, k=forward from stage k;
//                                       FWD_SEL_W=$clog2(FWD_DEPTH+1)
//  stall      out  1                    hold IF/ID, inject bubble into EX
// BEHAVIOUR
//  - Reset: all entries valid=0, cnt=0. Outputs are combinational from entries+ID inputs,
//    so stall=0 and fwd_sel=0 while reset is asserted. Reset mid-operation discards all entries.
//  - Entry k holds {valid, rd, cnt}. Every clk all entries shift k->k+1 unconditionally.
//    The oldest entry drops out. The next shifted cnt is max(cnt-1, 0).
//  - Entry 1 load: if id_valid & reg_we_id & rd_id!=x0 & !stall & !flush, it loads
//    {1, rd_id, min(lat_id, FWD_DEPTH-1)}. Otherwise entry 1 loads a bubble (valid=0).
//  - Match, src i: rs_used[i] & rs!=x0 & entry k valid & entry k rd==rs.
//    With several matching stages, the lowest k (youngest) wins.
//  - Winner cnt==0: fwd_sel[i]=k. Winner cnt!=0: hazard[i]=1, fwd_sel[i]=0.
//    No match: fwd_sel[i]=0.
//  - stall = id_valid & !flush & OR(hazard). flush has priority over stall.
//    While stall=1, the ID inputs must be held by the pipeline. Entries keep advancing,
//    so stall releases without extra logic once the producer's cnt reaches 0 or it leaves.
//  - Latency: zero-cycle combinational select/stall. Load-use with lat=1 gives exactly
//    1 stall cycle, then fwd_sel=2.
//  - x0: never recorded, never matched, always fwd_sel=0.
//  - id_valid=0: stall=0; fwd_sel is still computed (don't-care downstream).
//  - lat_id>FWD_DEPTH-1 is clamped. A simulation assertion flags it.
//  - Same rd in ID and in an entry: the ID instruction sees older producers only;
//    its own rd enters entry 1 next cycle.
// STRUCTURE
//  - ama_riscv_defines.v gains `FWD_SEL_RF (0), `FWD_SEL_EX (1), `FWD_SEL_MEM (2),
//    `FWD_SEL_WB (3), and reuses `RF_X0_ZERO.
//  - Sub-module ama_riscv_fwd_entry: one stage register {valid, rd, cnt} with async reset,
//    shift input and saturating decrement. Instantiate it FWD_DEPTH times via generate.
//  - Top level: entry chain, per-source priority match (generate over NUM_SRC),
//    stall OR-reduce.
// TESTING
//  1. ALU chain: add x5 (lat0), then next instr reads rs1=x5
//     -> fwd_sel[0]=1, stall=0; one instr later -> 2; two later -> 3; three later -> 0.
//  2. Load-use: lw x7 (lat1), next reads rs2=x7 -> stall=1 for exactly 1 cycle,
//     entry 1 bubble, then fwd_sel[1]=2, stall=0.
//  3. Priority: x3 written in stages 1 and 3 (both cnt 0) -> fwd_sel=1;
//     stage 1 cnt=1 -> stall=1, not forwarding from stage 3.
//  4. x0 and rs_used: producer rd=x0, or rs_used[i]=0 on a matching reg
//     -> fwd_sel[i]=0, stall=0, no entry recorded for the x0 write.
//  5. Flush over hazard: load-use condition with flush=1 -> stall=0, entry 1 bubble;
//     the following instr sees no entry for the flushed rd.
//  6. Async reset mid-stall: assert rst between edges with entries valid
//     -> stall=0, fwd_sel=0 immediately; after release, the same rs sees no match.

Source files
------------

// File: rtl/ama_riscv_fwd_scoreboard_pkg.sv
// Shared definitions for the operand-forwarding scoreboard.
//   fwd_sel_e  : operand-mux select encoding (RF, or forward from EX/MEM/WB)
//   RF_X0_ZERO : hard-wired zero register index, never tracked
package ama_riscv_fwd_scoreboard_pkg;

  typedef enum logic [1:0] {
    FWD_SEL_RF  = 2'd0,
    FWD_SEL_EX  = 2'd1,
    FWD_SEL_MEM = 2'd2,
    FWD_SEL_WB  = 2'd3
  } fwd_sel_e;

  localparam int unsigned RF_X0_ZERO = 0;

endpackage

// File: rtl/ama_riscv_fwd_entry.sv
// One tracked pipeline stage {valid, rd, cnt} of the forwarding scoreboard.
//   clk, rst     : clock, asynchronous active-high reset (clears the entry)
//   shift_valid  : valid bit shifted in from the younger stage (or ID)
//   shift_rd     : destination register shifted in
//   shift_cnt    : remaining latency shifted in
//   valid/rd/cnt : registered entry contents
// DEC_IN=1 applies a saturating decrement to the incoming count; the first
// stage loads the ID latency unmodified and uses DEC_IN=0.
module ama_riscv_fwd_entry #(
  parameter int unsigned RF_ADDR_W = 5,
  parameter int unsigned LAT_W     = 2,
  parameter bit          DEC_IN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_valid,
  input  logic [RF_ADDR_W-1:0] shift_rd,
  input  logic [LAT_W-1:0]     shift_cnt,
  output logic                 valid,
  output logic [RF_ADDR_W-1:0] rd,
  output logic [LAT_W-1:0]     cnt
);

  logic [LAT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = shift_cnt;
    if (DEC_IN && (shift_cnt != '0)) cnt_nxt = shift_cnt - LAT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      rd    <= '0;
      cnt   <= '0;
    end else begin
      valid <= shift_valid;
      rd    <= shift_rd;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/ama_riscv_fwd_scoreboard.sv
// Operand-forwarding and hazard unit for the ID stage.
// Tracks in-flight register writes over FWD_DEPTH stages (1=EX, 2=MEM, 3=WB),
// each with a result-latency countdown, and produces per-source forward
// selects (youngest matching producer wins) plus a load-use/multi-cycle stall.
//   clk, rst   : clock, asynchronous active-high reset
//   id_valid   : valid instruction in ID
//   rs_id      : source addresses, src i at [i*RF_ADDR_W +: RF_ADDR_W]
//   rs_used    : src i is read by the instruction
//   rd_id      : destination of the ID instruction
//   reg_we_id  : ID instruction writes rd
//   lat_id     : stages after EX entry until forwardable (0=ALU, 1=load)
//   flush      : kill the ID instruction
//   fwd_sel    : per src, 0=RF, k=forward from stage k (combinational)
//   stall      : hold IF/ID, inject bubble into EX (combinational)
module ama_riscv_fwd_scoreboard
  import ama_riscv_fwd_scoreboard_pkg::*;
#(
  parameter  int unsigned NUM_SRC   = 2,
  parameter  int unsigned RF_ADDR_W = 5,
  parameter  int unsigned FWD_DEPTH = 3,
  parameter  int unsigned LAT_W     = 2,
  localparam int unsigned FWD_SEL_W = $clog2(FWD_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [NUM_SRC*RF_ADDR_W-1:0]   rs_id,
  input  logic [NUM_SRC-1:0]             rs_used,
  input  logic [RF_ADDR_W-1:0]           rd_id,
  input  logic                           reg_we_id,
  input  logic [LAT_W-1:0]               lat_id,
  input  logic                           flush,
  output logic [NUM_SRC*FWD_SEL_W-1:0]   fwd_sel,
  output logic                           stall
);

  localparam logic [LAT_W-1:0]     MAX_LAT = LAT_W'(FWD_DEPTH - 1);
  localparam logic [RF_ADDR_W-1:0] X0      = RF_ADDR_W'(RF_X0_ZERO);

  // index k-1 holds stage k
  logic [FWD_DEPTH-1:0] e_valid;
  logic [RF_ADDR_W-1:0] e_rd  [FWD_DEPTH];
  logic [LAT_W-1:0]     e_cnt [FWD_DEPTH];

  logic [NUM_SRC-1:0]   hazard;
  logic [LAT_W-1:0]     lat_clamped;
  logic                 load_ok;

  assign lat_clamped = (lat_id > MAX_LAT) ? MAX_LAT : lat_id;
  assign load_ok     = id_valid & reg_we_id & (rd_id != X0) & ~stall & ~flush;

  for (genvar g = 0; g < FWD_DEPTH; g++) begin : g_entry
    if (g == 0) begin : g_head
      ama_riscv_fwd_entry #(
        .RF_ADDR_W (RF_ADDR_W),
        .LAT_W     (LAT_W),
        .DEC_IN    (1'b0)
      ) u_entry (
        .clk         (clk),
        .rst         (rst),
        .shift_valid (load_ok),
        .shift_rd    (rd_id),
        .shift_cnt   (lat_clamped),
        .valid       (e_valid[g]),
        .rd          (e_rd[g]),
        .cnt         (e_cnt[g])
      );
    end else begin : g_tail
      ama_riscv_fwd_entry #(
        .RF_ADDR_W (RF_ADDR_W),
        .LAT_W     (LAT_W),
        .DEC_IN    (1'b1)
      ) u_entry (
        .clk         (clk),
        .rst         (rst),
        .shift_valid (e_valid[g-1]),
        .shift_rd    (e_rd[g-1]),
        .shift_cnt   (e_cnt[g-1]),
        .valid       (e_valid[g]),
        .rd          (e_rd[g]),
        .cnt         (e_cnt[g])
      );
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [RF_ADDR_W-1:0] rs;
    logic [FWD_SEL_W-1:0] sel;
    logic                 haz;

    assign rs = rs_id[s*RF_ADDR_W +: RF_ADDR_W];

    // Scan oldest to youngest so the lowest matching stage is the last write.
    always_comb begin
      sel = FWD_SEL_W'(FWD_SEL_RF);
      haz = 1'b0;
      if (rs_used[s] && (rs != X0)) begin
        for (int unsigned k = FWD_DEPTH; k > 0; k--) begin
          if (e_valid[k-1] && (e_rd[k-1] == rs)) begin
            if (e_cnt[k-1] == '0) begin
              sel = FWD_SEL_W'(k);
              haz = 1'b0;
            end else begin
              sel = FWD_SEL_W'(FWD_SEL_RF);
              haz = 1'b1;
            end
          end
        end
      end
    end

    assign fwd_sel[s*FWD_SEL_W +: FWD_SEL_W] = sel;
    assign hazard[s] = haz;
  end

  assign stall = id_valid & ~flush & (|hazard);

  lat_range_chk : assert property (@(posedge clk) disable iff (rst)
    (id_valid && reg_we_id) |-> (lat_id <= MAX_LAT));

endmodule

// File: tb/tb_ama_riscv_fwd_scoreboard.sv
module tb_ama_riscv_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [9:0]  rs_id = '0;
  logic [1:0]  rs_used = '0;
  logic [4:0]  rd_id = '0;
  logic        reg_we_id = 1'b0;
  logic [1:0]  lat_id = '0;
  logic        flush = 1'b0;
  logic [3:0]  fwd_sel;
  logic        stall;

  ama_riscv_fwd_scoreboard #(
    .NUM_SRC   (2),
    .RF_ADDR_W (5),
    .FWD_DEPTH (3),
    .LAT_W     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .rs_id     (rs_id),
    .rs_used   (rs_used),
    .rd_id     (rd_id),
    .reg_we_id (reg_we_id),
    .lat_id    (lat_id),
    .flush     (flush),
    .fwd_sel   (fwd_sel),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic [1:0] s0;
    logic [1:0] s1;
    string      name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 1'b0;

  // Apply one ID-cycle of inputs just after the clock edge, queue the expected outputs.
  task automatic step(input logic r, input logic v,
                      input logic [4:0] a, input logic [4:0] b, input logic [1:0] u,
                      input logic [4:0] d, input logic w, input logic [1:0] l,
                      input logic f,
                      input logic es, input logic [1:0] e0, input logic [1:0] e1,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; rs_id = {b, a}; rs_used = u;
    rd_id = d; reg_we_id = w; lat_id = l; flush = f;
    e.stall = es; e.s0 = e0; e.s1 = e1; e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: outputs are valid mid-cycle; pop and compare one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (stall !== e.stall || fwd_sel[1:0] !== e.s0 || fwd_sel[3:2] !== e.s1) begin
          errors++;
          $display("FAIL %s: got stall=%b sel0=%0d sel1=%0d, want stall=%b sel0=%0d sel1=%0d",
                   e.name, stall, fwd_sel[1:0], fwd_sel[3:2], e.stall, e.s0, e.s1);
        end
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    //    rst v   rs1    rs2    used   rd     we l     f   stall s0 s1
    step(1, 0, 5'd0,  5'd0,  2'b00, 5'd0,  0, 2'd0, 0,  0, 2'd0, 2'd0, "reset");
    step(0, 0, 5'd0,  5'd0,  2'b00, 5'd0,  0, 2'd0, 0,  0, 2'd0, 2'd0, "idle");
    // ALU chain on x5
    step(0, 1, 5'd1,  5'd2,  2'b11, 5'd5,  1, 2'd0, 0,  0, 2'd0, 2'd0, "alu_prod");
    step(0, 1, 5'd5,  5'd0,  2'b01, 5'd6,  0, 2'd0, 0,  0, 2'd1, 2'd0, "alu_ex");
    step(0, 1, 5'd5,  5'd0,  2'b01, 5'd6,  0, 2'd0, 0,  0, 2'd2, 2'd0, "alu_mem");
    step(0, 1, 5'd5,  5'd0,  2'b01, 5'd6,  0, 2'd0, 0,  0, 2'd3, 2'd0, "alu_wb");
    step(0, 1, 5'd5,  5'd0,  2'b01, 5'd6,  0, 2'd0, 0,  0, 2'd0, 2'd0, "alu_rf");
    // load-use on x7
    step(0, 1, 5'd0,  5'd0,  2'b00, 5'd7,  1, 2'd1, 0,  0, 2'd0, 2'd0, "lw_prod");
    step(0, 1, 5'd0,  5'd7,  2'b10, 5'd8,  1, 2'd0, 0,  1, 2'd0, 2'd0, "lu_stall");
    step(0, 1, 5'd0,  5'd7,  2'b10, 5'd8,  1, 2'd0, 0,  0, 2'd0, 2'd2, "lu_release");
    step(0, 1, 5'd8,  5'd7,  2'b11, 5'd0,  0, 2'd0, 0,  0, 2'd1, 2'd3, "lu_after");
    // priority on x3: stages 1 and 3
    step(0, 1, 5'd0,  5'd0,  2'b00, 5'd3,  1, 2'd0, 0,  0, 2'd0, 2'd0, "pri_x3a");
    step(0, 1, 5'd0,  5'd0,  2'b00, 5'd9,  1, 2'd0, 0,  0, 2'd0, 2'd0, "pri_x9");
    step(0, 1, 5'd3,  5'd0,  2'b01, 5'd3,  1, 2'd0, 0,  0, 2'd2, 2'd0, "same_rd_older");
    step(0, 1, 5'd3,  5'd9,  2'b11, 5'd0,  0, 2'd0, 0,  0, 2'd1, 2'd2, "pri_youngest");
    step(0, 1, 5'd0,  5'd0,  2'b00, 5'd3,  1, 2'd1, 0,  0, 2'd0, 2'd0, "pri_lw_x3");
    step(0, 1, 5'd3,  5'd0,  2'b01, 5'd0,  0, 2'd0, 0,  1, 2'd0, 2'd0, "pri_no_old_fwd");
    step(0, 1, 5'd3,  5'd0,  2'b01, 5'd0,  0, 2'd0, 0,  0, 2'd2, 2'd0, "pri_release");
    // x0 and rs_used
    step(0, 1, 5'd3,  5'd3,  2'b00, 5'd0,  1, 2'd0, 0,  0, 2'd0, 2'd0, "unused_match");
    step(0, 1, 5'd0,  5'd0,  2'b11, 5'd0,  0, 2'd0, 0,  0, 2'd0, 2'd0, "x0_no_entry");
    step(0, 1, 5'd0,  5'd0,  2'b00, 5'd4,  1, 2'd1, 0,  0, 2'd0, 2'd0, "x4_lw");
    step(0, 1, 5'd4,  5'd1,  2'b10, 5'd0,  0, 2'd0, 0,  0, 2'd0, 2'd0, "unused_hazard");
    step(0, 1, 5'd1,  5'd4,  2'b11, 5'd0,  0, 2'd0, 0,  0, 2'd0, 2'd2, "used_src1");
    // flush over hazard
    step(0, 1, 5'd0,  5'd0,  2'b00, 5'd7,  1, 2'd1, 0,  0, 2'd0, 2'd0, "fl_lw");
    step(0, 1, 5'd0,  5'd7,  2'b10, 5'd10, 1, 2'd0, 1,  0, 2'd0, 2'd0, "flush_no_stall");
    step(0, 1, 5'd10, 5'd7,  2'b11, 5'd0,  0, 2'd0, 0,  0, 2'd0, 2'd2, "flush_no_entry");
    // async reset mid-stall (lat 2 keeps the stall alive across the reset)
    step(0, 1, 5'd0,  5'd0,  2'b00, 5'd11, 1, 2'd2, 0,  0, 2'd0, 2'd0, "rs_lw2");
    step(0, 1, 5'd11, 5'd0,  2'b01, 5'd0,  0, 2'd0, 0,  1, 2'd0, 2'd0, "rs_stall");
    step(1, 1, 5'd11, 5'd0,  2'b01, 5'd0,  0, 2'd0, 0,  0, 2'd0, 2'd0, "rst_async");
    step(0, 1, 5'd11, 5'd0,  2'b01, 5'd0,  0, 2'd0, 0,  0, 2'd0, 2'd0, "rst_cleared");
    step(0, 0, 5'd0,  5'd0,  2'b00, 5'd0,  0, 2'd0, 0,  0, 2'd0, 2'd0, "final_idle");

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
